// File: rtl/riscv_csr_pkg.sv
// Shared constants for the machine-mode interrupt CSR block: CSR addresses,
// csr_op encodings, FSM state encodings and the CSR read-modify-write helper.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_TRAP    = 3'd2;
    localparam logic [2:0] ST_HANDLER = 3'd3;
    localparam logic [2:0] ST_RET     = 3'd4;

    // Local interrupt k reports cause 16+k and lives at mie/mip bit 16+k.
    localparam int IRQ_CAUSE_OFFSET = 16;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef struct packed {
        logic stall;
        logic flush;
        logic ack;
        logic trap_take;
    } pipe_ctrl_t;

    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old_val | wdata;
            CSR_OP_CLEAR: res = old_val & ~wdata;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled-and-pending lines.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [3:0]   id_o,
    output logic         valid_o
);

    always_comb begin
        id_o    = '0;
        valid_o = |req_i;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_csr_unit.sv
// Machine-mode interrupt CSRs plus the drain/trap/handler/return sequencer
// that steers the pipeline into and out of interrupt handlers.
module irq_csr_unit
    import riscv_csr_pkg::*;
#(
    parameter int          NUM_IRQ   = 4,
    parameter int          PC_W      = 11,
    parameter logic [31:0] MTVEC_RST = 32'h41
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [11:0]        csr_raddr_i,
    input  logic [11:0]        csr_waddr_i,
    input  logic [31:0]        csr_wdata_i,
    input  logic [1:0]         csr_op_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               pipe_rdy_i,
    input  logic               mret_i,
    output logic [31:0]        csr_rdata_o,
    output logic [PC_W-1:0]    mepc_o,
    output logic [PC_W-1:0]    trap_addr_o,
    output logic               stall_o,
    output logic               flush_o,
    output logic               ack_o,
    output logic               trap_take_o,
    output logic [3:0]         irq_id_o,
    output logic [2:0]         fsm_state_o
);

    logic [2:0]         state_q, state_d;
    logic               mie_bit_q, mie_bit_d;
    logic               mpie_q, mpie_d;
    logic [NUM_IRQ-1:0] irq_en_q, irq_en_d;
    logic [NUM_IRQ-1:0] irq_pend_q;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [PC_W-1:0]    mepc_q, mepc_d;
    logic [PC_W-1:0]    trap_addr_q, trap_addr_d;
    logic [3:0]         irq_id_q, irq_id_d;
    logic [31:0]        csr_rdata_q, csr_rdata_d;

    logic [NUM_IRQ-1:0] irq_req;
    logic [3:0]         enc_id;
    logic               enc_valid;
    logic               pending;
    logic               enter_trap;
    logic [31:0]        mstatus_rd, mie_rd, mip_rd, mepc_rd;
    logic [31:0]        wr_old, wr_val;
    logic [PC_W-1:0]    tvec_base, vec_off;
    pipe_ctrl_t         ctrl;

    assign irq_req = irq_en_q & irq_pend_q;

    irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio_enc (
        .req_i   (irq_req),
        .id_o    (enc_id),
        .valid_o (enc_valid)
    );

    assign pending    = mie_bit_q & enc_valid;
    assign enter_trap = (state_q == ST_DRAIN) && pipe_rdy_i;

    // MPP is hard-wired to machine mode; every other unnamed bit reads 0.
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};
    assign mie_rd     = 32'(irq_en_q) << IRQ_CAUSE_OFFSET;
    assign mip_rd     = 32'(irq_pend_q) << IRQ_CAUSE_OFFSET;
    assign mepc_rd    = 32'(mepc_q);

    always_comb begin
        csr_rdata_d = '0;
        case (csr_raddr_i)
            CSR_MSTATUS:  csr_rdata_d = mstatus_rd;
            CSR_MIE:      csr_rdata_d = mie_rd;
            CSR_MIP:      csr_rdata_d = mip_rd;
            CSR_MTVEC:    csr_rdata_d = mtvec_q;
            CSR_MSCRATCH: csr_rdata_d = mscratch_q;
            CSR_MEPC:     csr_rdata_d = mepc_rd;
            CSR_MCAUSE:   csr_rdata_d = mcause_q;
            default:      csr_rdata_d = '0;
        endcase
    end

    always_comb begin
        wr_old = '0;
        case (csr_waddr_i)
            CSR_MSTATUS:  wr_old = mstatus_rd;
            CSR_MIE:      wr_old = mie_rd;
            CSR_MTVEC:    wr_old = mtvec_q;
            CSR_MSCRATCH: wr_old = mscratch_q;
            CSR_MEPC:     wr_old = mepc_rd;
            CSR_MCAUSE:   wr_old = mcause_q;
            default:      wr_old = '0;
        endcase
        wr_val = csr_apply(csr_op_i, wr_old, csr_wdata_i);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pending) state_d = ST_DRAIN;
            ST_DRAIN:   if (pipe_rdy_i) state_d = ST_TRAP;
            ST_TRAP:    state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (pending) begin
                    state_d = ST_DRAIN;
                end else if (mret_i) begin
                    state_d = ST_RET;
                end
            end
            ST_RET:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        irq_en_d   = irq_en_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mcause_d   = mcause_q;
        mepc_d     = mepc_q;
        irq_id_d   = irq_id_q;

        if (enter_trap) begin
            mepc_d    = pc_i;
            mcause_d  = {1'b1, 31'(IRQ_CAUSE_OFFSET + int'(enc_id))};
            irq_id_d  = enc_id;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end
        if (state_q == ST_RET) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end

        // Software writes land after the hardware updates so they win.
        if (csr_op_i != CSR_OP_NONE) begin
            case (csr_waddr_i)
                CSR_MSTATUS: begin
                    mie_bit_d = wr_val[MSTATUS_MIE_BIT];
                    mpie_d    = wr_val[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      irq_en_d   = wr_val[IRQ_CAUSE_OFFSET +: NUM_IRQ];
                CSR_MTVEC:    mtvec_d    = wr_val;
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d     = wr_val[PC_W-1:0];
                CSR_MCAUSE:   mcause_d   = wr_val;
                default: ;
            endcase
        end
    end

    // Built from next-state values so the registered target matches the CSRs.
    always_comb begin
        tvec_base = {mtvec_d[PC_W-1:2], 2'b00};
        vec_off   = PC_W'({mcause_d[4:0], 2'b00});
        if (mtvec_d[1:0] == 2'b01) begin
            trap_addr_d = tvec_base + vec_off;
        end else begin
            trap_addr_d = tvec_base;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            mie_bit_q   <= 1'b0;
            mpie_q      <= 1'b0;
            irq_en_q    <= '0;
            irq_pend_q  <= '0;
            mtvec_q     <= MTVEC_RST;
            mscratch_q  <= '0;
            mcause_q    <= '0;
            mepc_q      <= '0;
            irq_id_q    <= '0;
            trap_addr_q <= '0;
            csr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mie_bit_q   <= mie_bit_d;
            mpie_q      <= mpie_d;
            irq_en_q    <= irq_en_d;
            irq_pend_q  <= irq_i;
            mtvec_q     <= mtvec_d;
            mscratch_q  <= mscratch_d;
            mcause_q    <= mcause_d;
            mepc_q      <= mepc_d;
            irq_id_q    <= irq_id_d;
            trap_addr_q <= trap_addr_d;
            csr_rdata_q <= csr_rdata_d;
        end
    end

    always_comb begin
        ctrl.stall     = (state_q == ST_DRAIN);
        ctrl.flush     = (state_q == ST_DRAIN) || (state_q == ST_TRAP) || (state_q == ST_RET);
        ctrl.ack       = enter_trap;
        ctrl.trap_take = (state_q == ST_TRAP);
    end

    assign stall_o     = ctrl.stall;
    assign flush_o     = ctrl.flush;
    assign ack_o       = ctrl.ack;
    assign trap_take_o = ctrl.trap_take;
    assign csr_rdata_o = csr_rdata_q;
    assign mepc_o      = mepc_q;
    assign trap_addr_o = trap_addr_q;
    assign irq_id_o    = irq_id_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_irq_csr_unit.sv
// Directed vector bench for irq_csr_unit: a per-cycle table of inputs and
// hand-computed outputs, plus a hand-written reset-during-drain sequence.
module tb_irq_csr_unit;

    localparam int NUM_IRQ = 4;
    localparam int PC_W    = 11;

    localparam logic [2:0] S_IDLE = 3'd0, S_DRAIN = 3'd1, S_TRAP = 3'd2,
                           S_HANDLER = 3'd3, S_RET = 3'd4;
    localparam logic [1:0] OP_N = 2'b00, OP_W = 2'b01, OP_S = 2'b10, OP_C = 2'b11;
    // {stall, flush, ack, trap_take}
    localparam logic [3:0] F_NONE = 4'b0000, F_DRAIN = 4'b1100, F_DRAIN_ACK = 4'b1110,
                           F_TRAP = 4'b0101, F_RET = 4'b0100;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic [PC_W-1:0]    pc_i;
    logic [11:0]        csr_raddr_i, csr_waddr_i;
    logic [31:0]        csr_wdata_i;
    logic [1:0]         csr_op_i;
    logic [NUM_IRQ-1:0] irq_i;
    logic               pipe_rdy_i, mret_i;
    logic [31:0]        csr_rdata_o;
    logic [PC_W-1:0]    mepc_o, trap_addr_o;
    logic               stall_o, flush_o, ack_o, trap_take_o;
    logic [3:0]         irq_id_o;
    logic [2:0]         fsm_state_o;

    irq_csr_unit #(
        .NUM_IRQ   (NUM_IRQ),
        .PC_W      (PC_W),
        .MTVEC_RST (32'h41)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .pc_i        (pc_i),
        .csr_raddr_i (csr_raddr_i),
        .csr_waddr_i (csr_waddr_i),
        .csr_wdata_i (csr_wdata_i),
        .csr_op_i    (csr_op_i),
        .irq_i       (irq_i),
        .pipe_rdy_i  (pipe_rdy_i),
        .mret_i      (mret_i),
        .csr_rdata_o (csr_rdata_o),
        .mepc_o      (mepc_o),
        .trap_addr_o (trap_addr_o),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .ack_o       (ack_o),
        .trap_take_o (trap_take_o),
        .irq_id_o    (irq_id_o),
        .fsm_state_o (fsm_state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0]     ra;
        logic [11:0]     wa;
        logic [31:0]     wd;
        logic [1:0]      op;
        logic [3:0]      irq;
        logic            rdy;
        logic            mret;
        logic [PC_W-1:0] pc;
        logic [31:0]     e_rdata;
        logic [2:0]      e_state;
        logic [3:0]      e_flags;
        logic [3:0]      e_id;
        logic [PC_W-1:0] e_taddr;
        logic [PC_W-1:0] e_mepc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [11:0] ra, input logic [11:0] wa,
                                input logic [31:0] wd, input logic [1:0] op,
                                input logic [3:0] irq, input logic rdy, input logic mret,
                                input logic [PC_W-1:0] pc, input logic [31:0] e_rdata,
                                input logic [2:0] e_state, input logic [3:0] e_flags,
                                input logic [3:0] e_id, input logic [PC_W-1:0] e_taddr,
                                input logic [PC_W-1:0] e_mepc);
        vec_t v;
        v.ra = ra; v.wa = wa; v.wd = wd; v.op = op; v.irq = irq; v.rdy = rdy;
        v.mret = mret; v.pc = pc; v.e_rdata = e_rdata; v.e_state = e_state;
        v.e_flags = e_flags; v.e_id = e_id; v.e_taddr = e_taddr; v.e_mepc = e_mepc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        csr_raddr_i = v.ra;
        csr_waddr_i = v.wa;
        csr_wdata_i = v.wd;
        csr_op_i    = v.op;
        irq_i       = v.irq;
        pipe_rdy_i  = v.rdy;
        mret_i      = v.mret;
        pc_i        = v.pc;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " rdata"}, csr_rdata_o, v.e_rdata);
        chk({tag, " state"}, 32'(fsm_state_o), 32'(v.e_state));
        chk({tag, " flags"}, 32'({stall_o, flush_o, ack_o, trap_take_o}), 32'(v.e_flags));
        chk({tag, " irq_id"}, 32'(irq_id_o), 32'(v.e_id));
        chk({tag, " trap_addr"}, 32'(trap_addr_o), 32'(v.e_taddr));
        chk({tag, " mepc"}, 32'(mepc_o), 32'(v.e_mepc));
    endtask

    initial begin
        vec_t v;

        // Reset values, CSR read latency, set/clear on mstatus, read-only mip.
        vecs.push_back(mk(12'h305, 12'h000, 32'h0, OP_N, 4'b0000, 0, 0, 11'h100, 32'h41,       S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0000, 0, 0, 11'h100, 32'h1800,     S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h300, 12'h300, 32'h8, OP_S, 4'b0000, 0, 0, 11'h100, 32'h1800,     S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h300, 12'h300, 32'h8, OP_C, 4'b0000, 0, 0, 11'h100, 32'h1808,     S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0000, 0, 0, 11'h100, 32'h1800,     S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h344, 12'h344, 32'hFFFF_FFFF, OP_W, 4'b0101, 0, 0, 11'h100, 32'h0, S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h344, 12'h000, 32'h0, OP_N, 4'b0101, 0, 0, 11'h100, 32'h5_0000,   S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        // Enable lines 0 and 1, then global MIE: trap on line 0 with pipe ready.
        vecs.push_back(mk(12'h304, 12'h304, 32'h3_0000, OP_W, 4'b0011, 0, 0, 11'h100, 32'h0,   S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h304, 12'h300, 32'h8, OP_S, 4'b0011, 0, 0, 11'h100, 32'h3_0000,   S_IDLE, F_NONE, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h342, 12'h000, 32'h0, OP_N, 4'b0011, 1, 0, 11'h100, 32'h0,        S_DRAIN, F_DRAIN_ACK, 0, 11'h040, 11'h000));
        vecs.push_back(mk(12'h342, 12'h000, 32'h0, OP_N, 4'b0011, 1, 0, 11'h124, 32'h0,        S_TRAP, F_TRAP, 0, 11'h080, 11'h124));
        vecs.push_back(mk(12'h342, 12'h000, 32'h0, OP_N, 4'b0011, 0, 0, 11'h124, 32'h8000_0010, S_HANDLER, F_NONE, 0, 11'h080, 11'h124));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0011, 0, 0, 11'h124, 32'h1880,     S_HANDLER, F_NONE, 0, 11'h080, 11'h124));
        // mret: RET then IDLE with MIE restored.
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0011, 0, 1, 11'h124, 32'h1880,     S_RET, F_RET, 0, 11'h080, 11'h124));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0011, 0, 0, 11'h124, 32'h1880,     S_IDLE, F_NONE, 0, 11'h080, 11'h124));
        // Pending straight after RET; pipe not ready for 3 cycles; line 1 serviced.
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h300, 32'h1888,     S_DRAIN, F_DRAIN, 0, 11'h080, 11'h124));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h300, 32'h1888,     S_DRAIN, F_DRAIN, 0, 11'h080, 11'h124));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h300, 32'h1888,     S_DRAIN, F_DRAIN, 0, 11'h080, 11'h124));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0010, 1, 0, 11'h344, 32'h1888,     S_TRAP, F_TRAP, 1, 11'h084, 11'h344));
        vecs.push_back(mk(12'h342, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h344, 32'h8000_0011, S_HANDLER, F_NONE, 1, 11'h084, 11'h344));
        vecs.push_back(mk(12'h341, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h344, 32'h344,      S_HANDLER, F_NONE, 1, 11'h084, 11'h344));
        // mscratch write/clear, unmapped read, direct mode and wrapping vectored target.
        vecs.push_back(mk(12'h340, 12'h340, 32'hDEAD_BEEF, OP_W, 4'b0010, 0, 0, 11'h344, 32'h0, S_HANDLER, F_NONE, 1, 11'h084, 11'h344));
        vecs.push_back(mk(12'h340, 12'h340, 32'h0000_FFFF, OP_C, 4'b0010, 0, 0, 11'h344, 32'hDEAD_BEEF, S_HANDLER, F_NONE, 1, 11'h084, 11'h344));
        vecs.push_back(mk(12'h340, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h344, 32'hDEAD_0000, S_HANDLER, F_NONE, 1, 11'h084, 11'h344));
        vecs.push_back(mk(12'h7C0, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h344, 32'h0,        S_HANDLER, F_NONE, 1, 11'h084, 11'h344));
        vecs.push_back(mk(12'h305, 12'h305, 32'h100, OP_W, 4'b0010, 0, 0, 11'h344, 32'h41,     S_HANDLER, F_NONE, 1, 11'h100, 11'h344));
        vecs.push_back(mk(12'h305, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h344, 32'h100,      S_HANDLER, F_NONE, 1, 11'h100, 11'h344));
        vecs.push_back(mk(12'h342, 12'h305, 32'h7F1, OP_W, 4'b0010, 0, 0, 11'h344, 32'h8000_0011, S_HANDLER, F_NONE, 1, 11'h034, 11'h344));
        vecs.push_back(mk(12'h305, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h344, 32'h7F1,      S_HANDLER, F_NONE, 1, 11'h034, 11'h344));
        // mstatus write in the RET cycle beats the MIE/MPIE restore.
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0010, 0, 1, 11'h344, 32'h1880,     S_RET, F_RET, 1, 11'h034, 11'h344));
        vecs.push_back(mk(12'h300, 12'h300, 32'h0, OP_W, 4'b0010, 0, 0, 11'h344, 32'h1880,     S_IDLE, F_NONE, 1, 11'h034, 11'h344));
        vecs.push_back(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h344, 32'h1800,     S_IDLE, F_NONE, 1, 11'h034, 11'h344));

        // Clock/reset: hold reset for two edges and check every output is 0.
        reset_i = 1'b1;
        drive(mk(12'h0, 12'h0, 32'h0, OP_N, 4'b0, 0, 0, 11'h0, 32'h0, S_IDLE, F_NONE, 0, 11'h0, 11'h0));
        step();
        step();
        v = mk(12'h0, 12'h0, 32'h0, OP_N, 4'b0, 0, 0, 11'h0, 32'h0, S_IDLE, F_NONE, 0, 11'h0, 11'h0);
        check_vec("reset", v);
        reset_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            check_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset while draining: sequence is dropped, no mepc/mcause update.
        drive(mk(12'h300, 12'h300, 32'h8, OP_S, 4'b0010, 0, 0, 11'h555, 32'h0, S_IDLE, F_NONE, 0, 11'h0, 11'h0));
        step();
        chk("seq_rst idle", 32'(fsm_state_o), 32'(S_IDLE));
        drive(mk(12'h300, 12'h000, 32'h0, OP_N, 4'b0010, 0, 0, 11'h555, 32'h0, S_IDLE, F_NONE, 0, 11'h0, 11'h0));
        step();
        chk("seq_rst drain", 32'(fsm_state_o), 32'(S_DRAIN));
        chk("seq_rst stall", 32'(stall_o), 32'd1);
        drive(mk(12'h342, 12'h000, 32'h0, OP_N, 4'b0010, 1, 0, 11'h555, 32'h0, S_IDLE, F_NONE, 0, 11'h0, 11'h0));
        reset_i = 1'b1;
        step();
        v = mk(12'h0, 12'h0, 32'h0, OP_N, 4'b0, 0, 0, 11'h0, 32'h0, S_IDLE, F_NONE, 0, 11'h0, 11'h0);
        check_vec("seq_rst in_reset", v);
        reset_i = 1'b0;
        drive(mk(12'h342, 12'h000, 32'h0, OP_N, 4'b0000, 0, 0, 11'h555, 32'h0, S_IDLE, F_NONE, 0, 11'h0, 11'h0));
        step();
        chk("seq_rst mcause", csr_rdata_o, 32'h0);
        chk("seq_rst state", 32'(fsm_state_o), 32'(S_IDLE));
        chk("seq_rst taddr", 32'(trap_addr_o), 32'h40);
        csr_raddr_i = 12'h341;
        step();
        chk("seq_rst mepc_csr", csr_rdata_o, 32'h0);
        chk("seq_rst mepc_o", 32'(mepc_o), 32'h0);
        csr_raddr_i = 12'h300;
        step();
        chk("seq_rst mstatus", csr_rdata_o, 32'h1800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
